// File: rtl/addsub_pkg.sv
// Shared types and constants for the adder/subtracter operand entry path.
package addsub_pkg;

    typedef enum logic [1:0] {
        LOAD_A = 2'd0,
        LOAD_B = 2'd1,
        READY  = 2'd2
    } seq_state_t;

    localparam int DEBOUNCE_50MHZ_20MS = 1000000;

endpackage

// File: rtl/key_debounce.sv
// Pushbutton debouncer: accepts a level change only after DEBOUNCE_CYCLES stable
// cycles and emits a one-cycle press pulse the cycle after a 1-to-0 level flip.
module key_debounce
    import addsub_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_20MS
) (
    input  logic clk,
    input  logic reset,
    input  logic key_n,
    output logic level,
    output logic press
);

    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          level_q, level_d;
    logic          level_prev_q;
    logic          press_q;

    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (key_n != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = ~level_q;
            end else begin
                cnt_d = cnt_q + CW'(1);
            end
        end
    end

    // The pulse is derived from the already-registered level, so it lands
    // one cycle after the flip.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q        <= '0;
            level_q      <= 1'b1;
            level_prev_q <= 1'b1;
            press_q      <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            level_prev_q <= level_q;
            press_q      <= level_prev_q & ~level_q;
        end
    end

    assign level = level_q;
    assign press = press_q;

endmodule

// File: rtl/addsub_operand_sequencer.sv
// Operand entry sequencer: A, then B/sub, then show result, one key press per step.
// Optional ADDSUB_SEQ_SYNC_EN inserts a 2-flop synchronizer ahead of the debouncer.
module addsub_operand_sequencer
    import addsub_pkg::*;
#(
    parameter int WIDTH           = 4,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_50MHZ_20MS,
    parameter int CNT_WIDTH       = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic [WIDTH-1:0]     SW,
    input  logic                 sub_sw,
    input  logic                 key_n,
    output logic [WIDTH-1:0]     A,
    output logic [WIDTH-1:0]     B,
    output logic                 sub,
    output logic                 valid,
    output logic [1:0]           state,
    output logic [CNT_WIDTH-1:0] op_count
);

    logic key_deb_in;
    logic key_level;
    logic press;

`ifdef ADDSUB_SEQ_SYNC_EN
    logic [1:0] key_sync_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            key_sync_q <= 2'b11;
        end else begin
            key_sync_q <= {key_sync_q[0], key_n};
        end
    end

    assign key_deb_in = key_sync_q[1];
`else
    assign key_deb_in = key_n;
`endif

    key_debounce #(
        .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
    ) u_key_debounce (
        .clk  (clk),
        .reset(reset),
        .key_n(key_deb_in),
        .level(key_level),
        .press(press)
    );

    seq_state_t           state_q, state_d;
    logic [WIDTH-1:0]     a_q, a_d;
    logic [WIDTH-1:0]     b_q, b_d;
    logic                 sub_q, sub_d;
    logic                 valid_q, valid_d;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sub_d   = sub_q;
        valid_d = valid_q;
        cnt_d   = cnt_q;
        case (state_q)
            LOAD_A: begin
                if (press) begin
                    a_d     = SW;
                    state_d = LOAD_B;
                end
            end
            LOAD_B: begin
                if (press) begin
                    b_d     = SW;
                    sub_d   = sub_sw;
                    valid_d = 1'b1;
                    cnt_d   = cnt_q + CNT_WIDTH'(1);
                    state_d = READY;
                end
            end
            READY: begin
                if (press) begin
                    a_d     = '0;
                    b_d     = '0;
                    sub_d   = 1'b0;
                    valid_d = 1'b0;
                    state_d = LOAD_A;
                end
            end
            // Unused encoding 2'd3 falls back to the start of entry.
            default: state_d = LOAD_A;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= LOAD_A;
            a_q     <= '0;
            b_q     <= '0;
            sub_q   <= 1'b0;
            valid_q <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            sub_q   <= sub_d;
            valid_q <= valid_d;
            cnt_q   <= cnt_d;
        end
    end

    assign A        = a_q;
    assign B        = b_q;
    assign sub      = sub_q;
    assign valid    = valid_q;
    assign state    = state_q;
    assign op_count = cnt_q;

    // Debounced level is exposed by the sub-module but only the press pulse is used here.
    logic unused_level;
    assign unused_level = key_level;

endmodule
